instr_load_ram: RTL

Writable 256 × 21-bit instruction store that replaces the fixed ROM in `system`. Its read side presents the same combinational interface the CPU already uses: address in, 21-bit instruction out. Its write side is a byte-stream loader. It accepts a word count followed by 3-byte instruction words over a valid/ready handshake, assembles each word, and writes it at the next sequential address. It lets a program be streamed in from board switches or a host link instead of being re-synthesised.

---
 rtl/instr_load_ram.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_load_ram.sv
// Writable 256 x 21-bit instruction store with a byte-stream loader.
// The CPU read port is combinational. A session streams a word count, then 3 bytes per word.
module instr_load_ram #(
  parameter int          DEPTH       = 256,
  parameter logic [20:0] DEFAULT_INS = 21'b01_0_0111_000_000_00000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        load_en,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [7:0]  Addr,
  output logic [20:0] INS,
  output logic        loading,
  output logic        load_done,
  output logic [7:0]  word_ptr,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    B0,
    B1,
    B2,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       n_q, n_d;
  logic [8:0]       written_q, written_d;
  logic [7:0]       word_ptr_q, word_ptr_d;
  logic [4:0]       hdr_q, hdr_d;
  logic [7:0]       mid_q, mid_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [20:0]      mem [DEPTH];
  logic             mem_we;
  logic [20:0]      mem_wdata;
  logic             accept;

  assign byte_ready = (state_q == COUNT) || (state_q == B0) ||
                      (state_q == B1) || (state_q == B2);
  assign loading    = (state_q != IDLE);
  assign load_done  = (state_q == DONE);
  assign word_ptr   = word_ptr_q;
  assign err        = err_q;
  assign accept     = byte_valid && byte_ready;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    written_d  = written_q;
    word_ptr_d = word_ptr_q;
    hdr_d      = hdr_q;
    mid_d      = mid_q;
    err_d      = err_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    mem_wdata  = {hdr_q, mid_q, byte_in};

    // Dropping load_en mid-session aborts; a half-built word is simply discarded.
    case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d    = COUNT;
          valid_d    = '0;
          err_d      = 1'b0;
          word_ptr_d = 8'd0;
          written_d  = 9'd0;
        end
      end
      COUNT: begin
        if (!load_en) begin
          state_d = IDLE;
        end else if (accept) begin
          n_d     = (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
          state_d = B0;
        end
      end
      B0: begin
        if (!load_en) begin
          state_d = IDLE;
        end else if (accept) begin
          hdr_d = byte_in[4:0];
          if (byte_in[7:5] != 3'd0) begin
            err_d = 1'b1;
          end
          state_d = B1;
        end
      end
      B1: begin
        if (!load_en) begin
          state_d = IDLE;
        end else if (accept) begin
          mid_d   = byte_in;
          state_d = B2;
        end
      end
      B2: begin
        if (!load_en) begin
          state_d = IDLE;
        end else if (accept) begin
          mem_we              = 1'b1;
          valid_d[word_ptr_q] = 1'b1;
          word_ptr_d          = word_ptr_q + 8'd1;
          written_d           = written_q + 9'd1;
          // 9-bit count so that N=256 terminates even though word_ptr wraps to 0.
          state_d = ((written_q + 9'd1) == n_q) ? DONE : B0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      n_q        <= 9'd0;
      written_q  <= 9'd0;
      word_ptr_q <= 8'd0;
      hdr_q      <= 5'd0;
      mid_q      <= 8'd0;
      err_q      <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      written_q  <= written_d;
      word_ptr_q <= word_ptr_d;
      hdr_q      <= hdr_d;
      mid_q      <= mid_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  // Storage has no reset; the valid bits alone decide what is visible.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[word_ptr_q] <= mem_wdata;
    end
  end

  assign INS = (loading || !valid_q[Addr]) ? DEFAULT_INS : mem[Addr];

endmodule
